// File: rtl/slope_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : slope_arbiter_if
// Description : Bus bundle for slope_arbiter. Carries the per-channel sample
//               request/grant handshake and the registered trend result.
//               master : sample sources / result consumer
//               slave  : the slope_arbiter itself
//               Signals: req[NCH], data[NCH*WIDTH] (channel i at
//               [i*WIDTH +: WIDTH]), gnt[NCH] one-hot, out_valid, out_ch,
//               out_pos/out_neg/out_eq, out_peak/out_valley.
// Revision    : 1.0 - initial release
// ============================================================================
interface slope_arbiter_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int CHW   = 2
);
    logic [NCH-1:0]       req;
    logic [NCH*WIDTH-1:0] data;
    logic [NCH-1:0]       gnt;
    logic                 out_valid;
    logic [CHW-1:0]       out_ch;
    logic                 out_pos;
    logic                 out_neg;
    logic                 out_eq;
    logic                 out_peak;
    logic                 out_valley;

    modport master (
        output req, data,
        input  gnt, out_valid, out_ch, out_pos, out_neg, out_eq,
               out_peak, out_valley
    );

    modport slave (
        input  req, data,
        output gnt, out_valid, out_ch, out_pos, out_neg, out_eq,
               out_peak, out_valley
    );
endinterface
`default_nettype wire

// File: rtl/slope_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : slope_arbiter
// Description : Shares one unsigned magnitude comparator and trend tracker
//               across NCH sample channels. A round-robin arbiter grants one
//               requesting channel per cycle; the granted sample is compared
//               with that channel's previous sample and a registered result
//               (pos/neg/eq, peak/valley) appears one cycle later.
//               Ports: clk, rst (sync, active high), bus (slave modport).
// Revision    : 1.0 - initial release
// ============================================================================
module slope_arbiter #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int CHW   = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    slope_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        TR_FLAT = 2'd0,
        TR_RISE = 2'd1,
        TR_FALL = 2'd2
    } trend_t;

    // Per-channel state
    logic [WIDTH-1:0] r_prev   [NCH];
    trend_t           r_trend  [NCH];
    logic [NCH-1:0]   r_primed;
    logic [CHW-1:0]   r_last;

    // Result registers
    logic             r_valid;
    logic [CHW-1:0]   r_ch;
    logic             r_pos;
    logic             r_neg;
    logic             r_eq;
    logic             r_peak;
    logic             r_valley;

    // Arbitration
    logic [NCH-1:0]   w_gnt;
    logic             w_any;
    logic [CHW-1:0]   w_sel;
    logic [CHW-1:0]   w_cand;

    // Datapath
    logic [WIDTH-1:0] w_ch_data [NCH];
    logic [WIDTH-1:0] w_sample;
    logic [WIDTH-1:0] w_prev;
    logic             w_gt;
    logic             w_lt;
    logic             w_eq;
    trend_t           w_cur_trend;
    trend_t           w_next_trend;
    logic             w_peak;
    logic             w_valley;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign w_ch_data[gi] = bus.data[gi*WIDTH +: WIDTH];
    end

    // Search starts at the channel after the last one granted, so the
    // channel just served has the lowest priority on the next cycle.
    always_comb begin
        w_gnt  = '0;
        w_any  = 1'b0;
        w_sel  = '0;
        w_cand = '0;
        if (!rst) begin
            for (int i = 1; i <= NCH; i++) begin
                w_cand = CHW'((int'(r_last) + i) % NCH);
                if (!w_any && bus.req[w_cand]) begin
                    w_any         = 1'b1;
                    w_sel         = w_cand;
                    w_gnt[w_cand] = 1'b1;
                end
            end
        end
    end

    assign w_sample    = w_ch_data[w_sel];
    assign w_prev      = r_prev[w_sel];
    assign w_cur_trend = r_trend[w_sel];
    assign w_gt        = (w_sample > w_prev);
    assign w_lt        = (w_sample < w_prev);
    assign w_eq        = (w_sample == w_prev);

    // Equal samples leave the trend alone so a plateau does not hide a
    // later peak or valley. Leaving FLAT never reports an event.
    always_comb begin
        w_next_trend = w_cur_trend;
        w_peak       = 1'b0;
        w_valley     = 1'b0;
        if (w_gt) begin
            w_valley     = (w_cur_trend == TR_FALL);
            w_next_trend = TR_RISE;
        end else if (w_lt) begin
            w_peak       = (w_cur_trend == TR_RISE);
            w_next_trend = TR_FALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Pointer at the last channel makes channel 0 highest priority.
            r_last   <= CHW'(NCH - 1);
            r_primed <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_prev[i]  <= '0;
                r_trend[i] <= TR_FLAT;
            end
            r_valid  <= 1'b0;
            r_ch     <= '0;
            r_pos    <= 1'b0;
            r_neg    <= 1'b0;
            r_eq     <= 1'b0;
            r_peak   <= 1'b0;
            r_valley <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            r_pos    <= 1'b0;
            r_neg    <= 1'b0;
            r_eq     <= 1'b0;
            r_peak   <= 1'b0;
            r_valley <= 1'b0;
            if (w_any) begin
                r_last           <= w_sel;
                r_prev[w_sel]    <= w_sample;
                r_primed[w_sel]  <= 1'b1;
                // The priming sample only seeds prev_data; no result.
                if (r_primed[w_sel]) begin
                    r_trend[w_sel] <= w_next_trend;
                    r_valid        <= 1'b1;
                    r_ch           <= w_sel;
                    r_pos          <= w_gt;
                    r_neg          <= w_lt;
                    r_eq           <= w_eq;
                    r_peak         <= w_peak;
                    r_valley       <= w_valley;
                end
            end
        end
    end

    assign bus.gnt        = w_gnt;
    assign bus.out_valid  = r_valid;
    assign bus.out_ch     = r_ch;
    assign bus.out_pos    = r_pos;
    assign bus.out_neg    = r_neg;
    assign bus.out_eq     = r_eq;
    assign bus.out_peak   = r_peak;
    assign bus.out_valley = r_valley;

endmodule
`default_nettype wire

// File: tb/tb_slope_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_slope_arbiter
// Description : Directed self-checking bench for slope_arbiter (WIDTH=16,
//               NCH=4). Result flags are checked as one packed vector
//               {valid, pos, neg, eq, peak, valley}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slope_arbiter;

    localparam logic [5:0] c_NONE  = 6'b000000;
    localparam logic [5:0] c_POS   = 6'b110000;
    localparam logic [5:0] c_NEG   = 6'b101000;
    localparam logic [5:0] c_EQ    = 6'b100100;
    localparam logic [5:0] c_NEGPK = 6'b101010;
    localparam logic [5:0] c_POSVL = 6'b110001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    slope_arbiter_if #(.WIDTH(16), .NCH(4), .CHW(2)) bus ();

    slope_arbiter #(.WIDTH(16), .NCH(4), .CHW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [5:0] res;
    assign res = {bus.out_valid, bus.out_pos, bus.out_neg, bus.out_eq,
                  bus.out_peak, bus.out_valley};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1);
    end

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Single grant of one sample on one channel; returns at edge+1.
    task automatic post(input int ch, input logic [15:0] val);
        bus.data[ch*16 +: 16] = val;
        bus.req = 4'(1) << ch;
        @(posedge clk);
        #1;
        bus.req = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'hF;
        bus.data = '0;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++; $display("FAIL reset_gnt: got %b, need 0000", bus.gnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (res !== c_NONE) begin
            n_fail++; $display("FAIL reset_flags: got %b, need %b", res, c_NONE);
        end
        n_checks++;
        if (bus.out_ch !== 2'd0) begin
            n_fail++; $display("FAIL reset_ch: got %0d, need 0", bus.out_ch);
        end
        @(posedge clk); #1;
        bus.req = '0;
        rst = 1'b0;
    endtask

    task automatic test_single_channel();
        logic [15:0] s [6] = '{16'd10, 16'd20, 16'd30, 16'd25, 16'd25, 16'd40};
        logic [5:0]  e [6] = '{c_NONE, c_POS, c_POS, c_NEGPK, c_EQ, c_POSVL};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            bus.req = 4'b0001;
            bus.data[15:0] = s[k];
            #1;
            n_checks++;
            if (bus.gnt !== 4'b0001) begin
                n_fail++; $display("FAIL single_gnt[%0d]: got %b, need 0001", k, bus.gnt);
            end
            @(posedge clk); #1;
            n_checks++;
            if (res !== e[k]) begin
                n_fail++; $display("FAIL single_res[%0d]: got %b, need %b", k, res, e[k]);
            end
            if (k > 0) begin
                n_checks++;
                if (bus.out_ch !== 2'd0) begin
                    n_fail++; $display("FAIL single_ch[%0d]: got %0d, need 0", k, bus.out_ch);
                end
            end
        end
        bus.req = '0;
    endtask

    task automatic test_all_reqs();
        bus.data = {4{16'd7}};
        bus.req = 4'hF;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            n_checks++;
            if (bus.gnt !== (4'(1) << (c % 4))) begin
                n_fail++; $display("FAIL rr_gnt[%0d]: got %b, need %b", c, bus.gnt, 4'(1) << (c % 4));
            end
            @(posedge clk); #1;
            n_checks++;
            if (res !== ((c >= 4) ? c_EQ : c_NONE)) begin
                n_fail++; $display("FAIL rr_res[%0d]: got %b, need %b", c, res, (c >= 4) ? c_EQ : c_NONE);
            end
            if (c >= 4) begin
                n_checks++;
                if (bus.out_ch !== 2'(c % 4)) begin
                    n_fail++; $display("FAIL rr_ch[%0d]: got %0d, need %0d", c, bus.out_ch, c % 4);
                end
            end
        end
        bus.req = '0;
    endtask

    task automatic test_isolation();
        do_reset();
        post(1, 16'd100);
        n_checks++;
        if (res !== c_NONE) begin n_fail++; $display("FAIL iso_prime1: got %b, need %b", res, c_NONE); end
        post(2, 16'd5);
        n_checks++;
        if (res !== c_NONE) begin n_fail++; $display("FAIL iso_prime2: got %b, need %b", res, c_NONE); end
        post(1, 16'd50);
        n_checks++;
        if ({bus.out_ch, res} !== {2'd1, c_NEG}) begin
            n_fail++; $display("FAIL iso_ch1_neg: got ch%0d %b, need ch1 %b", bus.out_ch, res, c_NEG);
        end
        post(2, 16'd500);
        n_checks++;
        if ({bus.out_ch, res} !== {2'd2, c_POS}) begin
            n_fail++; $display("FAIL iso_ch2_pos: got ch%0d %b, need ch2 %b", bus.out_ch, res, c_POS);
        end
        post(1, 16'd60);
        n_checks++;
        if ({bus.out_ch, res} !== {2'd1, c_POSVL}) begin
            n_fail++; $display("FAIL iso_ch1_valley: got ch%0d %b, need ch1 %b", bus.out_ch, res, c_POSVL);
        end
        post(2, 16'd400);
        n_checks++;
        if ({bus.out_ch, res} !== {2'd2, c_NEGPK}) begin
            n_fail++; $display("FAIL iso_ch2_peak: got ch%0d %b, need ch2 %b", bus.out_ch, res, c_NEGPK);
        end
    endtask

    task automatic test_boundary();
        post(3, 16'h0000);
        n_checks++;
        if (res !== c_NONE) begin n_fail++; $display("FAIL bnd_prime: got %b, need %b", res, c_NONE); end
        post(3, 16'hFFFF);
        n_checks++;
        if ({bus.out_ch, res} !== {2'd3, c_POS}) begin
            n_fail++; $display("FAIL bnd_max_pos: got ch%0d %b, need ch3 %b", bus.out_ch, res, c_POS);
        end
        post(3, 16'h0000);
        n_checks++;
        if ({bus.out_ch, res} !== {2'd3, c_NEGPK}) begin
            n_fail++; $display("FAIL bnd_zero_peak: got ch%0d %b, need ch3 %b", bus.out_ch, res, c_NEGPK);
        end
        post(3, 16'hFFFF);
        n_checks++;
        if ({bus.out_ch, res} !== {2'd3, c_POSVL}) begin
            n_fail++; $display("FAIL bnd_max_valley: got ch%0d %b, need ch3 %b", bus.out_ch, res, c_POSVL);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        post(0, 16'd10);
        post(0, 16'd20);
        post(0, 16'd30);
        n_checks++;
        if (res !== c_POS) begin n_fail++; $display("FAIL mid_setup: got %b, need %b", res, c_POS); end
        bus.data[15:0] = 16'd40;
        bus.req = 4'b0001;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0000) begin
            n_fail++; $display("FAIL mid_gnt_in_rst: got %b, need 0000", bus.gnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req = '0;
        n_checks++;
        if (res !== c_NONE) begin n_fail++; $display("FAIL mid_suppressed: got %b, need %b", res, c_NONE); end
        post(0, 16'd10);
        n_checks++;
        if (res !== c_NONE) begin n_fail++; $display("FAIL mid_reprime: got %b, need %b", res, c_NONE); end
        post(0, 16'd5);
        n_checks++;
        if ({bus.out_ch, res} !== {2'd0, c_NEG}) begin
            n_fail++; $display("FAIL mid_neg_nopeak: got ch%0d %b, need ch0 %b", bus.out_ch, res, c_NEG);
        end
    endtask

    task automatic test_idle();
        post(1, 16'd77);
        post(1, 16'd80);
        n_checks++;
        if ({bus.out_ch, res} !== {2'd1, c_POS}) begin
            n_fail++; $display("FAIL idle_setup: got ch%0d %b, need ch1 %b", bus.out_ch, res, c_POS);
        end
        bus.req = '0;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b, need 0000", bus.gnt); end
        @(posedge clk); #1;
        n_checks++;
        if (res !== c_NONE) begin n_fail++; $display("FAIL idle_res: got %b, need %b", res, c_NONE); end
        n_checks++;
        if (bus.out_ch !== 2'd1) begin n_fail++; $display("FAIL idle_ch_hold: got %0d, need 1", bus.out_ch); end
        @(posedge clk); #1;
        bus.req = 4'b1100;
        #1;
        n_checks++;
        if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL idle_ptr_kept: got %b, need 0100", bus.gnt); end
        @(posedge clk); #1;
        n_checks++;
        if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL idle_ptr_next: got %b, need 1000", bus.gnt); end
        @(posedge clk); #1;
        bus.req = '0;
    endtask

    initial begin
        bus.req  = '0;
        bus.data = '0;
        test_reset();
        test_single_channel();
        test_all_reqs();
        test_isolation();
        test_boundary();
        test_reset_mid();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slope_arbiter.md
Name: slope_arbiter

Overview:
- Time-multiplexes one WIDTH-bit magnitude comparator and slope/trend tracker across NCH independent sample channels.
- Each channel posts a sample with a req/gnt handshake. A round-robin arbiter grants one channel per cycle.
- The block compares the granted sample against that channel's stored previous sample, updates the channel's trend state, and emits one registered result per grant (rising/falling/equal, plus peak/valley events).
- Sits between the sample sources and downstream event logic; replaces one slope detector per channel.

Parameters:
- WIDTH, 16, sample width in bits (unsigned).
- NCH, 4, number of channels (2..16).
- CHW, 2, channel index width; must equal ceil(log2(NCH)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NCH  per-channel sample request; held high with stable data until granted.
- data  input  NCH*WIDTH  channel i sample at bits [i*WIDTH +: WIDTH].
- gnt  output  NCH  one-hot combinational grant; sample is consumed on the clock edge where req[i]&gnt[i].
- out_valid  output  1  registered; high one cycle per primed-channel grant.
- out_ch  output  CHW  channel index of the current result.
- out_pos  output  1  granted sample > channel's previous sample.
- out_neg  output  1  granted sample < channel's previous sample.
- out_eq  output  1  granted sample == channel's previous sample.
- out_peak  output  1  trend changed RISE -> FALL on this sample.
- out_valley  output  1  trend changed FALL -> RISE on this sample.

Behaviour:
- Reset (rst high at a clock edge):
  - All registered outputs go to 0.
  - All channels become unprimed with trend FLAT.
  - prev_data registers go to 0.
  - The round-robin pointer points so that channel 0 has highest priority.
  - gnt is all-zero while rst is high.
- Arbitration:
  - gnt is combinational from req and the pointer. It selects the first requesting channel, searching upward (modulo NCH) from the channel after the last granted one.
  - At most one bit is set; gnt is all-zero when req is all-zero.
  - The pointer updates only on a cycle with a grant.
  - A continuously requesting channel waits at most NCH-1 cycles.
- Per-channel state (updated only when granted):
  - prev_data[WIDTH], primed bit, trend in {FLAT, RISE, FALL}.
- First grant to an unprimed channel:
  - Store the sample and set primed.
  - Trend stays FLAT; out_valid stays 0 on the next cycle.
- Grant to a primed channel: compare the sample against prev_data (unsigned), then store the sample.
  - Next cycle: out_valid=1, out_ch=index, exactly one of out_pos/out_neg/out_eq set.
- Trend transitions:
  - pos: FLAT->RISE, FALL->RISE (out_valley=1), RISE->RISE.
  - neg: FLAT->FALL, RISE->FALL (out_peak=1), FALL->FALL.
  - eq: trend unchanged, no event. A plateau inside a rise or fall does not break the pending peak/valley detection.
  - Moving out of FLAT never produces peak or valley.
- Latency and throughput:
  - Result registers are valid exactly 1 cycle after the granting edge.
  - Full throughput is one result per cycle.
  - When there is no grant, out_valid=0 and all flags are 0; out_ch holds its last value.
- Simultaneous events:
  - Multiple reqs resolve by round-robin only.
  - A grant and a result for a different channel in the same cycle are independent.
- Reset mid-stream:
  - Any pending result is discarded (outputs 0 on the next cycle).
  - All channels must re-prime.
- Extreme values: 0 vs 2^WIDTH-1 compares correctly with no wrap or sign interpretation.

Test Plan:
- Reset, then req[0] only with samples 10, 20, 30, 25, 25, 40 on consecutive grants:
  - No result for 10.
  - Then pos, pos, neg+peak, eq (no event), pos+valley.
  - out_ch=0 throughout; each result 1 cycle after its grant.
- All four reqs held high continuously from reset:
  - Grants follow 0,1,2,3,0,1,... with one-hot gnt.
  - First four grants produce no out_valid; out_valid then stays high every cycle.
- Channel isolation:
  - Interleave ch1 (100 -> 50) and ch2 (5 -> 500) grants.
  - ch1 reports neg, ch2 reports pos.
  - No cross-channel trend or peak contamination.
- Boundary values on ch3, samples 0, 0xFFFF, 0:
  - Results are pos, then neg+peak.
  - Then 0xFFFF again gives pos+valley.
- Reset mid-stream:
  - After ch0 has trend RISE with prev=30, assert rst for one cycle during a grant. That result is suppressed.
  - Next ch0 sample of 10 produces no result (re-prime).
  - Following sample of 5 gives neg with no peak.
- req deasserted on all channels:
  - gnt=0 and out_valid=0 the following cycle.
  - Pointer unchanged: the next req from channels 2 and 3 after last grant to 1 grants channel 2.
